// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronises rxd, validates the start bit, samples
// data/parity/stop at bit centres using the oversample tick, and presents each
// word with a one-cycle valid strobe plus parity/framing flags.
module uart_rx_deframer #(
  parameter int DATA_BITS   = 8,
  parameter int OVS         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic                 rxd,
  input  logic                 bclk_rx,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic                 rx_bclk_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int TW = (OVS > 1) ? $clog2(OVS) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] TICK_HALF = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] START    = 3'd1;
  localparam logic [2:0] DATA     = 3'd2;
  localparam logic [2:0] PARITY   = 3'd3;
  localparam logic [2:0] STOP     = 3'd4;
  localparam logic [2:0] BRK_WAIT = 3'd5;

  logic [2:0]             state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rxd_s;
  logic [TW-1:0]          tick_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shift;
  logic                   par_en_q;
  logic                   par_odd_q;
  logic                   par_err_q;

  assign rxd_s   = sync[SYNC_STAGES-1];
  assign rx_busy = (state != IDLE);

  // Input synchroniser; resets to the idle (high) line level.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      sync <= '1;
    end else begin
      sync[0] <= rxd;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync[i] <= sync[i-1];
      end
    end
  end

  // Frame state machine, tick/bit counters, shift register and result registers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state      <= IDLE;
      rx_bclk_en <= 1'b0;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      par_err_q  <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            state      <= START;
            rx_bclk_en <= 1'b1;
            tick_cnt   <= '0;
            par_en_q   <= parity_en;
            par_odd_q  <= parity_odd;
            par_err_q  <= 1'b0;
          end
        end
        START: begin
          if (bclk_rx) begin
            if (tick_cnt == TICK_HALF) begin
              tick_cnt <= '0;
              if (!rxd_s) begin
                state   <= DATA;
                bit_cnt <= '0;
              end else begin
                state      <= IDLE;
                rx_bclk_en <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (bclk_rx) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              shift    <= {rxd_s, shift[DATA_BITS-1:1]};
              if (bit_cnt == BIT_LAST) begin
                state <= par_en_q ? PARITY : STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (bclk_rx) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt  <= '0;
              par_err_q <= ((^shift) ^ rxd_s) != par_odd_q;
              state     <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (bclk_rx) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt   <= '0;
              rx_valid   <= 1'b1;
              rx_data    <= shift;
              frame_err  <= ~rxd_s;
              parity_err <= par_en_q & par_err_q;
              rx_bclk_en <= 1'b0;
              state      <= rxd_s ? IDLE : BRK_WAIT;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        BRK_WAIT: begin
          if (rxd_s) begin
            state <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          rx_bclk_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: frame-level model (expected word queue) checked
// every cycle, plus directed scenarios with literal expectations.
module tb_uart_rx_deframer;

  localparam int DB  = 8;
  localparam int OVS = 16;
  localparam int DIV = 4;
  localparam int BIT = OVS * DIV;

  logic          pclk = 1'b0;
  logic          presetn;
  logic          rxd;
  logic          bclk_rx = 1'b0;
  logic          parity_en;
  logic          parity_odd;
  logic          rx_bclk_en;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          parity_err;
  logic          frame_err;
  logic          rx_busy;

  int checks   = 0;
  int failures = 0;
  int nvalid   = 0;

  typedef struct {
    logic [DB-1:0] data;
    logic          perr;
    logic          ferr;
  } exp_t;

  exp_t q[$];

  logic [DB-1:0] last_data;
  logic          last_perr;
  logic          last_ferr;

  uart_rx_deframer #(
    .DATA_BITS  (DB),
    .OVS        (OVS),
    .SYNC_STAGES(2)
  ) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .rxd       (rxd),
    .bclk_rx   (bclk_rx),
    .parity_en (parity_en),
    .parity_odd(parity_odd),
    .rx_bclk_en(rx_bclk_en),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 pclk = ~pclk;

  // Baud generator stand-in: divide by DIV while enabled, first tick one cycle after enable.
  int unsigned bdiv = 0;
  always @(posedge pclk) begin
    if (!rx_bclk_en) begin
      bdiv    <= 0;
      bclk_rx <= 1'b0;
    end else begin
      bclk_rx <= (bdiv == 0);
      bdiv    <= (bdiv == DIV - 1) ? 0 : bdiv + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_perr(input logic [DB-1:0] d, input logic pen,
                                      input logic podd, input logic pbit);
    int ones;
    ones = 0;
    for (int i = 0; i < DB; i++) ones += int'(d[i]);
    ones += int'(pbit);
    return pen ? ((ones % 2) != int'(podd)) : 1'b0;
  endfunction

  // Every cycle out of reset: strobes must match queued frames, outputs hold between strobes.
  always @(negedge pclk) begin
    if (!presetn) begin
      last_data = '0;
      last_perr = 1'b0;
      last_ferr = 1'b0;
    end else begin
      if (rx_valid) begin
        nvalid++;
        chk("valid_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          exp_t e;
          e = q.pop_front();
          last_data = e.data;
          last_perr = e.perr;
          last_ferr = e.ferr;
        end
      end
      chk("rx_data", rx_data, last_data);
      chk("parity_err", parity_err, last_perr);
      chk("frame_err", frame_err, last_ferr);
      if (!rx_busy) chk("bclk_en_when_idle", rx_bclk_en, 0);
    end
  end

  task automatic hold(input logic v, input int n);
    rxd = v;
    repeat (n) @(negedge pclk);
  endtask

  // Sends a frame with the current parity config; leaves rxd at the stop level.
  task automatic send_frame(input logic [DB-1:0] d, input logic pbit, input logic stop);
    exp_t e;
    e.data = d;
    e.perr = model_perr(d, parity_en, parity_odd, pbit);
    e.ferr = ~stop;
    q.push_back(e);
    hold(1'b0, BIT);
    for (int i = 0; i < DB; i++) hold(d[i], BIT);
    if (parity_en) hold(pbit, BIT);
    hold(stop, BIT);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rx_valid"}, rx_valid, 0);
    chk({tag, "_rx_data"}, rx_data, 0);
    chk({tag, "_parity_err"}, parity_err, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_rx_busy"}, rx_busy, 0);
    chk({tag, "_rx_bclk_en"}, rx_bclk_en, 0);
  endtask

  initial begin
    int v0;
    int en_cnt;
    logic [DB-1:0] aa;

    rxd        = 1'b1;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    presetn    = 1'b0;
    repeat (3) @(negedge pclk);
    chk_reset_vals("reset");
    presetn = 1'b1;
    hold(1'b1, 10);

    // 0xA5, no parity, good stop
    v0 = nvalid;
    send_frame(8'hA5, 1'b0, 1'b1);
    hold(1'b1, 10);
    chk("a5_count", nvalid - v0, 1);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_perr", parity_err, 0);
    chk("a5_ferr", frame_err, 0);
    chk("a5_bclk_en", rx_bclk_en, 0);
    chk("a5_busy", rx_busy, 0);

    // Even parity: 0x03 has two ones, so parity bit 1 is wrong, 0 is right
    parity_en  = 1'b1;
    parity_odd = 1'b0;
    send_frame(8'h03, 1'b1, 1'b1);
    hold(1'b1, 10);
    chk("p03_bad_data", rx_data, 8'h03);
    chk("p03_bad_perr", parity_err, 1);
    send_frame(8'h03, 1'b0, 1'b1);
    hold(1'b1, 10);
    chk("p03_good_perr", parity_err, 0);

    // Odd parity: 0x07 has three ones, parity bit 1 makes four -> error
    parity_odd = 1'b1;
    send_frame(8'h07, 1'b1, 1'b1);
    parity_en = 1'b0;
    hold(1'b1, 10);
    chk("p07_odd_perr", parity_err, 1);
    parity_odd = 1'b0;

    // False start: 12 cycles low
    v0 = nvalid;
    en_cnt = 0;
    rxd = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (i == 12) rxd = 1'b1;
      @(negedge pclk);
      if (rx_bclk_en) en_cnt++;
    end
    chk("false_start_count", nvalid - v0, 0);
    chk("false_start_en_seen", en_cnt > 0, 1);
    chk("false_start_en_le32", en_cnt <= 32, 1);
    chk("false_start_busy", rx_busy, 0);

    // Bad stop followed by a break held for the rest of 5 bit times
    v0 = nvalid;
    send_frame(8'h55, 1'b0, 1'b0);
    hold(1'b0, 2 * BIT);
    chk("brk_count", nvalid - v0, 1);
    chk("brk_data", rx_data, 8'h55);
    chk("brk_ferr", frame_err, 1);
    chk("brk_busy", rx_busy, 1);
    chk("brk_bclk_en", rx_bclk_en, 0);
    hold(1'b0, 2 * BIT);
    chk("brk_no_retrigger", nvalid - v0, 1);
    chk("brk_still_busy", rx_busy, 1);
    hold(1'b1, 10);
    chk("brk_release_busy", rx_busy, 0);

    // Back-to-back frames
    v0 = nvalid;
    send_frame(8'h12, 1'b0, 1'b1);
    send_frame(8'h34, 1'b0, 1'b1);
    hold(1'b1, 10);
    chk("b2b_count", nvalid - v0, 2);
    chk("b2b_data", rx_data, 8'h34);
    chk("b2b_ferr", frame_err, 0);

    // Reset during data bit 4, then a clean 0xFF
    v0 = nvalid;
    aa = 8'hAA;
    hold(1'b0, BIT);
    for (int i = 0; i < 4; i++) hold(aa[i], BIT);
    hold(aa[4], BIT / 2);
    presetn = 1'b0;
    rxd     = 1'b1;
    repeat (3) @(negedge pclk);
    chk_reset_vals("midreset");
    presetn = 1'b1;
    hold(1'b1, 10);
    send_frame(8'hFF, 1'b0, 1'b1);
    hold(1'b1, 10);
    chk("ff_count", nvalid - v0, 1);
    chk("ff_data", rx_data, 8'hFF);
    chk("ff_ferr", frame_err, 0);
    chk("ff_perr", parity_err, 0);

    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
